// File: rtl/uart_pkg.sv
// Shared definitions for the UART baud-rate controller: rate table, defaults and FSM states.
package uart_pkg;

    localparam int unsigned DEF_DIV_BITS = 9;
    localparam int unsigned DEF_RST_RATE = 4;
    localparam int unsigned NUM_RATES    = 8;

    // Divisor per rate index, DIV = round(50 MHz / (16 * baud)) - 1; index 7 is the MSB slot.
    localparam logic [NUM_RATES-1:0][DEF_DIV_BITS-1:0] RATE_DIV = {
        9'd2,   // 7: 921600
        9'd6,   // 6: 460800
        9'd13,  // 5: 230400
        9'd26,  // 4: 115200
        9'd53,  // 3: 57600
        9'd80,  // 2: 38400
        9'd162, // 1: 19200
        9'd325  // 0: 9600
    };

    typedef enum logic [1:0] {
        StRun,
        StDrain,
        StLoad
    } state_e;

    function automatic logic [DEF_DIV_BITS-1:0] rate_div(input logic [2:0] idx);
        return RATE_DIV[idx];
    endfunction

endpackage

// File: rtl/baud_timer.sv
// Divide-by-(div+1) tick counter with run enable and synchronous clear.
// tick is registered; tick_next is its next-state value for same-cycle bookkeeping upstream.
module baud_timer #(
    parameter int unsigned DIV_BITS = 9
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                clear,
    input  logic [DIV_BITS-1:0] div,
    output logic                tick_next,
    output logic                tick
);

    logic [DIV_BITS-1:0] count_q, count_d;
    logic                tick_q;

    // Next count: clear wins, otherwise advance and wrap while enabled.
    always_comb begin
        count_d   = count_q;
        tick_next = 1'b0;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d   = (count_q >= div) ? '0 : count_q + 1'b1;
            tick_next = (count_d == div);
        end
    end

    // Count and registered tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            tick_q  <= tick_next;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/uart_baud_ctrl.sv
// Baud-rate controller: 16x and bit-rate tick source with rate changes deferred until
// both serial paths are idle.
module uart_baud_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned DIV_BITS = DEF_DIV_BITS,
    parameter int unsigned RST_RATE = DEF_RST_RATE
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       cfg_valid,
    input  logic [2:0] cfg_rate,
    output logic       cfg_ready,
    input  logic       tx_busy,
    input  logic       rx_busy,
    output logic       tx_hold,
    output logic       tick_16x,
    output logic       tick_bit,
    output logic [2:0] cur_rate,
    output logic       cfg_done
);

    localparam logic [2:0]          RstIdx = 3'(RST_RATE);
    localparam logic [DIV_BITS-1:0] RstDiv = DIV_BITS'(rate_div(RstIdx));

    state_e              state_q, state_d;
    logic [2:0]          pend_q, pend_d;
    logic [2:0]          rate_q;
    logic [DIV_BITS-1:0] div_q;
    logic [3:0]          sub_q, sub_d;
    logic                tick_bit_q, tick_bit_d;
    logic                tick_next;
    logic                clear;

    // Clearing on entry to LOAD as well as during it keeps the LOAD cycle tick-free.
    assign clear = (state_q == StLoad) || (state_d == StLoad);

    baud_timer #(
        .DIV_BITS (DIV_BITS)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .clear     (clear),
        .div       (div_q),
        .tick_next (tick_next),
        .tick      (tick_16x)
    );

    // Next-state logic: accept in RUN, wait for idle in DRAIN, single-cycle LOAD.
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        unique case (state_q)
            StRun: begin
                if (cfg_valid) begin
                    state_d = StDrain;
                    pend_d  = cfg_rate;
                end
            end
            StDrain: begin
                if (!tx_busy && !rx_busy) begin
                    state_d = StLoad;
                end
            end
            StLoad:  state_d = StRun;
            default: state_d = StRun;
        endcase
    end

    // State and pending-rate registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StRun;
            pend_q  <= RstIdx;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
        end
    end

    // Applied rate and divisor, updated only in LOAD.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q  <= RstDiv;
            rate_q <= RstIdx;
        end else if (state_q == StLoad) begin
            div_q  <= DIV_BITS'(rate_div(pend_q));
            rate_q <= pend_q;
        end
    end

    // Sub counter: every 16th 16x tick is also a bit tick.
    always_comb begin
        sub_d      = sub_q;
        tick_bit_d = 1'b0;
        if (clear) begin
            sub_d = '0;
        end else if (tick_next) begin
            tick_bit_d = (sub_q == 4'hF);
            sub_d      = sub_q + 4'd1;
        end
    end

    // Sub counter and registered bit tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sub_q      <= '0;
            tick_bit_q <= 1'b0;
        end else begin
            sub_q      <= sub_d;
            tick_bit_q <= tick_bit_d;
        end
    end

    // Handshake and status outputs decode the state register directly.
    assign cfg_ready = (state_q == StRun);
    assign tx_hold   = (state_q != StRun);
    assign cfg_done  = (state_q == StLoad);
    assign tick_bit  = tick_bit_q;
    assign cur_rate  = rate_q;

endmodule

// File: doc/uart_baud_ctrl.md
# uart_baud_ctrl

Baud-rate controller for the UART. Owns the divide-by-N tick counter and runs it as a 16x oversampling tick source for the receiver and a bit-rate tick source for the transmitter. Accepts runtime rate-change requests over a valid/ready handshake and applies them only when both serial paths are idle, so no frame is corrupted. It sits between the register interface and the UART TX/RX datapaths.

## Interface
- DIV_BITS, 9, width of the divisor and tick counter; must hold the largest table entry (325).
- RST_RATE, 4, rate index loaded at reset (115200 baud).
- clk  in  1  system clock, 50 MHz
- reset  in  1  asynchronous, active-high reset
- enable  in  1  global run enable; low freezes both counters and suppresses ticks
- cfg_valid  in  1  rate-change request
- cfg_rate  in  3  requested rate index, 0..7
- cfg_ready  out  1  high only in RUN; handshake completes when cfg_valid && cfg_ready
- tx_busy  in  1  transmitter mid-frame
- rx_busy  in  1  receiver mid-frame
- tx_hold  out  1  high in DRAIN and LOAD; TX must not start a new frame
- tick_16x  out  1  one-cycle pulse at 16x baud
- tick_bit  out  1  one-cycle pulse at baud; coincides with every 16th tick_16x
- cur_rate  out  3  rate index currently applied
- cfg_done  out  1  one-cycle pulse in the LOAD cycle

## Operation
- Rate table, DIV = round(50e6/(16*baud)) - 1: idx0 9600 = 325, idx1 19200 = 162, idx2 38400 = 80, idx3 57600 = 53, idx4 115200 = 26, idx5 230400 = 13, idx6 460800 = 6, idx7 921600 = 2.
- Tick counter: counts 0..div_reg, then wraps to 0. tick_16x is asserted when count == div_reg and enable is high. Period is div_reg + 1 cycles.
- Sub counter: 4 bits, advances on each tick_16x. tick_bit = tick_16x && sub == 15; sub then wraps to 0.
- FSM states RUN, DRAIN, LOAD:
  - RUN: cfg_ready = 1. On handshake, capture cfg_rate into pending and go to DRAIN.
  - DRAIN: ticks continue at the old rate; tx_hold = 1. When !tx_busy && !rx_busy in the same cycle, go to LOAD. There is no timeout; DRAIN waits indefinitely.
  - LOAD: exactly one cycle. div_reg <= table[pending], cur_rate <= pending, both counters <= 0. No ticks this cycle. cfg_done = 1. Next state is RUN.
- A request for the already-applied index still passes through DRAIN and LOAD, which realigns tick phase.
- cfg_valid while cfg_ready is low is ignored and not queued.
- enable low: counters hold and no ticks are issued; the FSM still advances. enable does not block LOAD.

## Timing
- Reset values: state RUN, div_reg = 26, cur_rate = 4, counters 0, cfg_ready 1, tx_hold 0, tick_16x 0, tick_bit 0, cfg_done 0.
- Handshake to DRAIN: 1 cycle. cfg_ready drops the cycle after acceptance.
- DRAIN to LOAD: the cycle after both busy inputs are sampled low. If both are already idle at acceptance, the sequence is RUN, DRAIN (1 cycle), LOAD, RUN.
- After LOAD, the count is 0 in the first RUN cycle. The first tick_16x occurs in RUN cycle number div_reg + 1. The first tick_bit occurs at 16 × (div_reg + 1).
- Outputs tick_16x, tick_bit, cfg_done, cfg_ready and tx_hold are registered, with no combinational path from inputs.
- Reset asserted in any state returns everything to the reset values immediately. A pending request is discarded.

## Structure
- uart_pkg holds:
  - the DIV_BITS default
  - the 8-entry rate table as a constant array, plus a lookup function
  - the FSM state enum
  - the RST_RATE default
- Sub-module baud_timer is the loadable divide-by-(div+1) counter with enable, synchronous clear and a one-cycle tick output. uart_baud_ctrl instantiates it and owns the FSM, the sub counter and the handshake.

## Test plan
- Reset, enable = 1, busy inputs low -> tick_16x every 27 cycles, tick_bit every 432 cycles, cur_rate = 4, cfg_ready = 1.
- Request cfg_rate = 0 while idle -> DRAIN lasts 1 cycle, then cfg_done, cur_rate = 0. tick_16x every 326 cycles, first tick 326 cycles after LOAD.
- Request rate 7 while tx_busy is high for 500 cycles -> tx_hold = 1 and 27-cycle ticks continue throughout. LOAD occurs the cycle after tx_busy falls, then ticks arrive every 3 cycles.
- cfg_valid pulsed again during DRAIN with rate 2 -> ignored, and cur_rate ends at the first requested value.
- enable low for 10 cycles at count 20 -> count holds at 20 with no ticks. The next tick comes 7 cycles after enable returns high.
- Assert reset mid-DRAIN with rx_busy high -> all outputs return to reset values immediately and the pending rate is discarded. The 27-cycle tick resumes after reset is released.
